// File: rtl/inst_prefetch_unit.sv
// Decoupled RV32I fetch front end: sequential PC, credit-limited memory
// requests, DEPTH-entry instruction buffer, redirect with stale-response drop.
module inst_prefetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];

  logic [CW:0] credit;
  logic        issue;
  logic        push;
  logic        pop;

  always_comb begin
    credit         = {1'b0, count_q} + {1'b0, out_q};
    imem_req_valid = reset && !redirect_valid && (credit < DEPTH_W);
    issue          = imem_req_valid && imem_req_ready;
    push           = reset && imem_rsp_valid && !redirect_valid
                     && (stale_q == '0);
    inst_valid     = reset && (count_q != '0) && !redirect_valid;
    pop            = inst_valid && inst_ready;
    imem_addr      = reset ? fetch_pc_q : RESET_PC;
    inst_data      = reset ? data_q[rd_q] : '0;
    inst_pc        = reset ? pc_q[rd_q] : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    stale_d    = stale_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    out_d      = out_q + CW'(issue) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      rsp_pc_d   = redirect_pc & ~XLEN'(3);
      stale_d    = out_q - CW'(imem_rsp_valid);
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && stale_q != '0) stale_d = stale_q - CW'(1);
      if (push) begin
        data_d[wr_q] = imem_rsp_data;
        pc_d[wr_q]   = rsp_pc_q;
        wr_d         = wr_q + PW'(1);
        rsp_pc_d     = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule
